// File: rtl/run_length_logger.sv
// run_length_logger: measures each contiguous high interval of z, counts completed
// runs, and buffers run lengths in a first-word-fall-through FIFO drained by a
// valid/ready port. A sticky overflow flag records any dropped length.
module run_length_logger #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned EVT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_len,
  output logic [EVT_W-1:0] event_count,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LEN_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   occ_q;

  logic run_end;
  logic pop;
  logic push;
  logic full;
  logic drop;

  // Run completion, FIFO handshake and drop decision
  always_comb begin
    run_end   = (state_q == StRun) && !z;
    out_valid = (occ_q != '0);
    out_len   = mem_q[rd_ptr_q];
    pop       = out_valid && out_ready;
    full      = (occ_q == OCC_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push      = run_end && (!full || pop);
    drop      = run_end && full && !pop;
  end

  // Run-tracking FSM with registered busy, event counter and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      busy        <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (z) begin
            state_q <= StRun;
            len_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            busy    <= 1'b1;
          end
        end
        StRun: begin
          if (z) begin
            if (len_q != LEN_MAX) begin
              len_q <= len_q + 1'b1;
            end
          end else begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            event_count <= event_count + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= len_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        occ_q <= occ_q + 1'b1;
      end else if (pop && !push) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_length_logger.sv
// Bench for run_length_logger: directed runs against a queue-based model of run
// lengths, checked every cycle, plus literal expectations per scenario.
module tb_run_length_logger;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EVT_W  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int          LENMAX = (1 << CNT_W) - 1;
  localparam int          EVTMOD = 1 << EVT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             z = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [CNT_W-1:0] out_len;
  logic [EVT_W-1:0] event_count;
  logic             busy;
  logic             overflow;

  run_length_logger #(
    .CNT_W(CNT_W),
    .EVT_W(EVT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .z          (z),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_len    (out_len),
    .event_count(event_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  // Model: a run counter and a queue of completed lengths
  bit in_run;
  int run_len;
  int fifo[$];
  int evt;
  bit ovf;
  int pops;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    in_run  = 0;
    run_len = 0;
    fifo.delete();
    evt     = 0;
    ovf     = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit after
  task automatic step(input logic zv, input logic rdy);
    int l;
    z         = zv;
    out_ready = rdy;
    @(posedge clk);
    if (fifo.size() > 0 && rdy) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (in_run && !zv) begin
      l = (run_len > LENMAX) ? LENMAX : run_len;
      if (fifo.size() < int'(DEPTH)) fifo.push_back(l);
      else ovf = 1;
      evt++;
      in_run = 0;
    end else if (zv) begin
      if (in_run) run_len++;
      else begin
        in_run  = 1;
        run_len = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    z = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), int'(in_run));
      chk("out_valid", int'(out_valid), int'(fifo.size() > 0));
      chk("event_count", int'(event_count), evt % EVTMOD);
      chk("overflow", int'(overflow), int'(ovf));
      if (fifo.size() > 0) chk("out_len", int'(out_len), fifo[0]);
    end
  end

  int exp2[4];
  int exp3[4];

  initial begin
    model_clear();
    pops = 0;
    @(posedge clk);
    #1;
    do_reset();
    cmp_en = 1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_len", int'(out_len), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_evt", int'(event_count), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Single run of 3, held without reading
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("t1_busy", int'(busy), 1);
    end
    step(1'b0, 1'b0);
    chk("t1_busy_low", int'(busy), 0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_len", int'(out_len), 3);
    chk("t1_evt", int'(event_count), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("t1_hold", int'(out_len), 3);
    end

    // Fill, overflow on a fifth run, then drain in order
    do_reset();
    run(1);
    run(2);
    run(5);
    run(7);
    chk("t2_ovf0", int'(overflow), 0);
    run(4);
    chk("t2_ovf1", int'(overflow), 1);
    chk("t2_evt", int'(event_count), 5);
    exp2 = '{1, 2, 5, 7};
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", int'(out_valid), 1);
      chk("t2_drain", int'(out_len), exp2[i]);
      step(1'b0, 1'b1);
    end
    chk("t2_empty", int'(out_valid), 0);

    // Run ending on the same edge as a pop of a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) run(1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("t3_ovf", int'(overflow), 0);
    exp3 = '{1, 1, 1, 3};
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", int'(out_len), exp3[i]);
      step(1'b0, 1'b1);
    end
    chk("t3_empty", int'(out_valid), 0);

    // Saturation of a 300-cycle run
    do_reset();
    run(300);
    chk("t4_sat", int'(out_len), 255);

    // Event counter wrap with continuous draining
    do_reset();
    pops = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("t5_evt", int'(event_count), 0);
    chk("t5_pops", pops, 256);

    // Asynchronous reset in cycle 4 of a run, run restarts from release
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_len", int'(out_len), 0);
    chk("t6_evt", int'(event_count), 0);
    chk("t6_ovf", int'(overflow), 0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t6_newlen", int'(out_len), 5);
    chk("t6_newevt", int'(event_count), 1);
    step(1'b0, 1'b0);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
